vga_fb_arbiter: RTL

VGA_FB_ARBITER -- requirements
Module: vga_fb_arbiter

---
 rtl/vga_fb_pkg.sv | 15 +
 rtl/vga_fb_fifo.sv | 58 +++++
 rtl/vga_fb_arbiter.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/vga_fb_pkg.sv
// vga_fb_pkg: shared types and default constants for the VGA framebuffer arbiter.
//   arb_state_e : slot currently driven to the SRAM (idle, display read, writer write, flush).
//   DEF_*       : default parameter values used by vga_fb_arbiter.
package vga_fb_pkg;

    typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_FLUSH} arb_state_e;

    localparam int DEF_ADDR_W      = 19;
    localparam int DEF_DATA_W      = 16;
    localparam int DEF_FIFO_DEPTH  = 4;
    localparam int DEF_H_ACT       = 640;
    localparam int DEF_V_ACT       = 480;
    localparam int DEF_WR_MAX_WAIT = 8;

endpackage

// File: rtl/vga_fb_fifo.sv
// vga_fb_fifo: display prefetch FIFO with synchronous clear and occupancy count.
//   clk_i, rst_ni : clock and asynchronous active-low reset
//   clr_i         : empties the FIFO, overriding push and pop
//   push_i/data_i : write one word (ignored when full without a pop)
//   pop_i         : advance the head (ignored when empty)
//   head_o        : word at the head, valid while count_o != 0
//   count_o       : number of stored words
module vga_fb_fifo
    import vga_fb_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_FIFO_DEPTH
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       clr_i,
    input  logic                       push_i,
    input  logic [DATA_W-1:0]          data_i,
    input  logic                       pop_i,
    output logic [DATA_W-1:0]          head_o,
    output logic [$clog2(DEPTH):0]     count_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              do_push, do_pop;

    always_comb begin
        do_pop   = pop_i && count_q != '0;
        do_push  = push_i && (count_q != CNT_W'(DEPTH) || do_pop);
        wr_ptr_d = clr_i ? '0 : wr_ptr_q + PTR_W'(do_push);
        rd_ptr_d = clr_i ? '0 : rd_ptr_q + PTR_W'(do_pop);
        count_d  = clr_i ? '0 : count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push && !clr_i) mem_q[wr_ptr_q] <= data_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter: single-port SRAM arbiter between a display prefetch reader and a pixel writer.
//   iCLK, iRST_N          : pixel clock, asynchronous active-low reset (released synchronously)
//   iFRAME_START          : vertical-blank pulse, restarts the read stream at address 0
//   iPIX_REQ / oPIX_DATA  : display pop, data one cycle later (0 on an empty pop)
//   oUNDERFLOW            : sticky, set by any empty pop, cleared only by reset
//   iWR_REQ/ADDR/DATA     : writer request held until oWR_ACK
//   oWR_ACK               : one-cycle acknowledge, coincident with the SRAM write
//   oMEM_ADDR/WE/WDATA    : registered SRAM controls
//   iMEM_RDATA            : SRAM read data, one cycle after its address
// Optional feature: define VGA_FB_ARB_STARVE_EN to let a writer that has waited WR_MAX_WAIT
// cycles pre-empt reads while the FIFO holds at least two words.
module vga_fb_arbiter
    import vga_fb_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH,
    parameter int H_ACT       = DEF_H_ACT,
    parameter int V_ACT       = DEF_V_ACT,
    parameter int WR_MAX_WAIT = DEF_WR_MAX_WAIT
) (
    input  logic              iCLK,
    input  logic              iRST_N,
    input  logic              iFRAME_START,
    input  logic              iPIX_REQ,
    output logic [DATA_W-1:0] oPIX_DATA,
    output logic              oUNDERFLOW,
    input  logic              iWR_REQ,
    input  logic [ADDR_W-1:0] iWR_ADDR,
    input  logic [DATA_W-1:0] iWR_DATA,
    output logic              oWR_ACK,
    output logic [ADDR_W-1:0] oMEM_ADDR,
    output logic              oMEM_WE,
    output logic [DATA_W-1:0] oMEM_WDATA,
    input  logic [DATA_W-1:0] iMEM_RDATA
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int OCC_W = CNT_W + 1;
    localparam logic [ADDR_W-1:0] RD_END = ADDR_W'(H_ACT * V_ACT);

    if (FIFO_DEPTH < 2 || WR_MAX_WAIT < 1) begin : g_bad_cfg
        $error("vga_fb_arbiter: FIFO_DEPTH must be >= 2 and WR_MAX_WAIT >= 1");
    end

    // Reset asserts immediately but releases two clock edges later.
    logic rst_s1_q, rst_s2_q, rst_n;
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            rst_s1_q <= 1'b0;
            rst_s2_q <= 1'b0;
        end else begin
            rst_s1_q <= 1'b1;
            rst_s2_q <= rst_s1_q;
        end
    end
    assign rst_n = rst_s2_q;

    arb_state_e        state_q, state_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d, rd_base, mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d, pix_q, pix_d, fifo_head;
    logic              mem_we_q, mem_we_d, pend_q, underflow_q, underflow_d;
    logic [CNT_W-1:0]  fifo_cnt, cnt_eff;
    logic [OCC_W-1:0]  occ;
    logic              flush, push, pop, rd_ok, wr_ok, wr_first;

    // During the flush slot the FIFO, read pointer and returning read are treated as already
    // cleared, so the first post-flush read is decided in that same slot.
    always_comb begin
        flush       = state_q == S_FLUSH;
        cnt_eff     = flush ? '0 : fifo_cnt;
        rd_base     = flush ? '0 : rd_addr_q;
        push        = pend_q && !flush;
        pop         = iPIX_REQ && !flush && fifo_cnt != '0;
        occ         = OCC_W'(cnt_eff) + OCC_W'(push) + OCC_W'(state_q == S_READ);
        rd_ok       = rd_base < RD_END && occ < OCC_W'(FIFO_DEPTH);
        wr_ok       = iWR_REQ && state_q != S_WRITE;
        state_d     = iFRAME_START ? S_FLUSH :
                      wr_first     ? S_WRITE :
                      rd_ok        ? S_READ  :
                      wr_ok        ? S_WRITE : S_IDLE;
        rd_addr_d   = state_d == S_READ ? rd_base + ADDR_W'(1) : rd_base;
        mem_addr_d  = state_d == S_READ  ? rd_base  :
                      state_d == S_WRITE ? iWR_ADDR : mem_addr_q;
        mem_we_d    = state_d == S_WRITE;
        mem_wdata_d = mem_we_d ? iWR_DATA : mem_wdata_q;
        pix_d       = pop ? fifo_head : iPIX_REQ ? '0 : pix_q;
        underflow_d = underflow_q || (iPIX_REQ && !pop);
    end

`ifdef VGA_FB_ARB_STARVE_EN
    localparam int WAIT_W = $clog2(WR_MAX_WAIT + 1);
    logic [WAIT_W-1:0] wait_q, wait_d;
    always_comb begin
        wait_d   = (!iWR_REQ || mem_we_q) ? '0 :
                   wait_q == WAIT_W'(WR_MAX_WAIT) ? wait_q : wait_q + WAIT_W'(1);
        wr_first = wr_ok && wait_q == WAIT_W'(WR_MAX_WAIT) && cnt_eff >= CNT_W'(2);
    end
    always_ff @(posedge iCLK or negedge rst_n) begin
        if (!rst_n) wait_q <= '0;
        else        wait_q <= wait_d;
    end
`else
    assign wr_first = 1'b0;
`endif

    always_ff @(posedge iCLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            rd_addr_q   <= '0;
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
            pend_q      <= 1'b0;
            pix_q       <= '0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_addr_q   <= rd_addr_d;
            mem_addr_q  <= mem_addr_d;
            mem_we_q    <= mem_we_d;
            mem_wdata_q <= mem_wdata_d;
            pend_q      <= state_q == S_READ;
            pix_q       <= pix_d;
            underflow_q <= underflow_d;
        end
    end

    vga_fb_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i   (iCLK),
        .rst_ni  (rst_n),
        .clr_i   (flush),
        .push_i  (push),
        .data_i  (iMEM_RDATA),
        .pop_i   (pop),
        .head_o  (fifo_head),
        .count_o (fifo_cnt)
    );

    assign oMEM_ADDR  = mem_addr_q;
    assign oMEM_WE    = mem_we_q;
    assign oMEM_WDATA = mem_wdata_q;
    assign oWR_ACK    = mem_we_q;
    assign oPIX_DATA  = pix_q;
    assign oUNDERFLOW = underflow_q;

endmodule
